// File: rtl/frame_pad_sequencer.sv
// Zero-pads an unpadded pixel stream by ADD_CELLS cells on every side and tags each
// output beat with padded row/col, line/frame markers and a full-filter-window flag.
//
// state  | meaning
// IDLE   | waiting for SOF; non-SOF beats are accepted and dropped
// PAD    | emitting zero border beats, input held off
// ACTIVE | forwarding one input pixel per output beat
// DONE   | last beat loaded, waiting for it to be taken
module frame_pad_sequencer #(
  parameter int PIX_DEPTH    = 4,
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 8,
  parameter int FILTER_SIZE  = 5,
  parameter int ADD_CELLS    = (FILTER_SIZE - 1) / 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [PIX_DEPTH-1:0] s_tdata,
  input  logic                 s_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [PIX_DEPTH-1:0] m_tdata,
  output logic [1:0]           m_tuser,
  output logic                 m_twin,
  output logic [7:0]           m_row,
  output logic [7:0]           m_col,
  output logic                 frame_done,
  output logic                 err_sync
);

  localparam int PW = FRAME_WIDTH + 2 * ADD_CELLS;
  localparam int PH = FRAME_HEIGHT + 2 * ADD_CELLS;

  localparam logic [7:0] C_PW_M1   = 8'(PW - 1);
  localparam logic [7:0] C_PH_M1   = 8'(PH - 1);
  localparam logic [7:0] C_ADD     = 8'(ADD_CELLS);
  localparam logic [7:0] C_COL_END = 8'(ADD_CELLS + FRAME_WIDTH);
  localparam logic [7:0] C_ROW_END = 8'(ADD_CELLS + FRAME_HEIGHT);
  localparam logic [7:0] C_WIN     = 8'(2 * ADD_CELLS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PAD    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [7:0]           r_nrow;
  logic [7:0]           r_ncol;
  logic                 r_mvalid;
  logic [PIX_DEPTH-1:0] r_mdata;
  logic [1:0]           r_muser;
  logic                 r_mtwin;
  logic [7:0]           r_mrow;
  logic [7:0]           r_mcol;
  logic                 r_fdone;
  logic                 r_err;

  logic       w_load_ok;
  logic       w_wrap;
  logic       w_last;
  logic       w_next_active;
  logic       w_first_pix;
  logic       w_accept;
  logic       w_load;
  logic [7:0] w_nrow_nx;
  logic [7:0] w_ncol_nx;

  // r_nrow/r_ncol always name the cell the next output-register load will carry.
  always_comb begin
    w_load_ok     = !r_mvalid || m_tready;
    w_wrap        = (r_ncol == C_PW_M1);
    w_last        = w_wrap && (r_nrow == C_PH_M1);
    w_ncol_nx     = w_wrap ? 8'd0 : r_ncol + 8'd1;
    w_nrow_nx     = w_wrap ? r_nrow + 8'd1 : r_nrow;
    w_next_active = (w_nrow_nx >= C_ADD) && (w_nrow_nx < C_ROW_END) &&
                    (w_ncol_nx >= C_ADD) && (w_ncol_nx < C_COL_END);
    w_first_pix   = (r_nrow == C_ADD) && (r_ncol == C_ADD);
    s_tready      = resetn && ((r_state == S_IDLE) || ((r_state == S_ACTIVE) && w_load_ok));
    w_accept      = s_tvalid && s_tready;
    w_load        = ((r_state == S_PAD) && w_load_ok) || ((r_state == S_ACTIVE) && w_accept);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_nrow   <= 8'd0;
      r_ncol   <= 8'd0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_muser  <= 2'b00;
      r_mtwin  <= 1'b0;
      r_mrow   <= 8'd0;
      r_mcol   <= 8'd0;
      r_fdone  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fdone <= 1'b0;
      r_err   <= 1'b0;

      if (w_load) begin
        r_mvalid <= 1'b1;
        r_mdata  <= (r_state == S_ACTIVE) ? s_tdata : '0;
        r_mrow   <= r_nrow;
        r_mcol   <= r_ncol;
        r_muser  <= {(r_nrow == 8'd0) && (r_ncol == 8'd0), r_ncol == 8'd0};
        r_mtwin  <= (r_nrow >= C_WIN) && (r_ncol >= C_WIN);
        if (w_last) begin
          r_nrow <= 8'd0;
          r_ncol <= 8'd0;
        end else begin
          r_nrow <= w_nrow_nx;
          r_ncol <= w_ncol_nx;
        end
      end else if (m_tready) begin
        r_mvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE:   if (s_tvalid && s_tuser) r_state <= S_PAD;
        S_PAD,
        S_ACTIVE: if (w_load) r_state <= w_last ? S_DONE : (w_next_active ? S_ACTIVE : S_PAD);
        S_DONE: begin
          if (!r_mvalid || m_tready) begin
            r_state <= S_IDLE;
            r_fdone <= 1'b1;
          end
        end
        default:  r_state <= S_IDLE;
      endcase

      // The SOF pixel itself lands in ACTIVE at the first active cell; only later SOFs are errors.
      if ((r_state == S_ACTIVE) && w_accept && s_tuser && !w_first_pix) r_err <= 1'b1;
    end
  end

  assign m_tvalid   = r_mvalid;
  assign m_tdata    = r_mdata;
  assign m_tuser    = r_muser;
  assign m_twin     = r_mtwin;
  assign m_row      = r_mrow;
  assign m_col      = r_mcol;
  assign frame_done = r_fdone;
  assign err_sync   = r_err;

endmodule

// File: tb/tb_frame_pad_sequencer.sv
// Bench for frame_pad_sequencer: random pixel frames, gaps and backpressure checked against
// a geometric model of the padded frame.
module tb_frame_pad_sequencer;
  localparam int PD = 4;
  localparam int W  = 10;
  localparam int H  = 8;
  localparam int FS = 5;
  localparam int A  = (FS - 1) / 2;
  localparam int PW = W + 2 * A;
  localparam int PH = H + 2 * A;
  localparam int NB = PW * PH;
  localparam int NP = W * H;

  typedef struct {
    logic [PD-1:0] data;
    logic [7:0]    row;
    logic [7:0]    col;
    logic [1:0]    user;
    logic          twin;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [PD-1:0] data;
    logic          user;
    int            frame;
    bit            start;
  } item_t;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [PD-1:0] s_tdata = '0;
  logic          s_tuser = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [PD-1:0] m_tdata;
  logic [1:0]    m_tuser;
  logic          m_twin;
  logic [7:0]    m_row;
  logic [7:0]    m_col;
  logic          frame_done;
  logic          err_sync;

  frame_pad_sequencer #(
    .PIX_DEPTH(PD), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FILTER_SIZE(FS)
  ) dut (
    .clock(clock), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_twin(m_twin), .m_row(m_row), .m_col(m_col),
    .frame_done(frame_done), .err_sync(err_sync)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int err_cnt = 0;
  int stall_err = 0;
  int hold_err = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int fd_q[$];
  item_t items[$];
  logic [PD-1:0] pix[$];
  bit prev_stall = 0;
  beat_t prev_b;
  beat_t mon_b;

  // Downstream ready: 0 always, 1 the repeating 1,0,0,1 pattern, otherwise random.
  always @(posedge clock) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) begin
    if (resetn) begin
      mon_b.data = m_tdata; mon_b.row = m_row; mon_b.col = m_col;
      mon_b.user = m_tuser; mon_b.twin = m_twin; mon_b.cyc = cyc;
      if (prev_stall && (!m_tvalid || mon_b.data !== prev_b.data || mon_b.row !== prev_b.row ||
                         mon_b.col !== prev_b.col || mon_b.user !== prev_b.user))
        stall_err++;
      if (m_tvalid && m_tready) got_q.push_back(mon_b);
      if (frame_done) fd_q.push_back(cyc);
      if (err_sync) err_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_b = mon_b;
    end else begin
      prev_stall = 0;
    end
  end

  // Expected padded frame built from geometry over the pixels starting at pix[base].
  function automatic void add_frame(input int base);
    beat_t e;
    int r, c;
    for (int k = 0; k < NB; k++) begin
      r = k / PW;
      c = k % PW;
      e.row  = 8'(r);
      e.col  = 8'(c);
      e.data = (r >= A && r < A + H && c >= A && c < A + W) ? pix[base + (r - A) * W + (c - A)] : '0;
      e.user = {(r == 0) && (c == 0), c == 0};
      e.twin = (r >= 2 * A) && (c >= 2 * A);
      e.cyc  = 0;
      exp_q.push_back(e);
    end
  endfunction

  task automatic make_frame(input int n_junk, input int err_idx, input int fr, input bit seq);
    item_t it;
    for (int j = 0; j < n_junk; j++) begin
      it.data = PD'($urandom); it.user = 1'b0; it.frame = fr; it.start = 1'b0;
      items.push_back(it);
    end
    for (int p = 1; p <= NP; p++) begin
      it.data  = seq ? PD'(p) : PD'($urandom);
      it.user  = (p == 1) || (p == err_idx);
      it.frame = fr;
      it.start = (p == 1);
      items.push_back(it);
      pix.push_back(it.data);
    end
  endtask

  task automatic start_test(input int mode);
    ready_mode = mode;
    items.delete(); pix.delete(); exp_q.delete(); got_q.delete(); fd_q.delete();
    err_cnt = 0; stall_err = 0; hold_err = 0;
    repeat (2) @(posedge clock);
  endtask

  // A frame-start pixel is handshaken once in IDLE without being consumed, then again in ACTIVE.
  task automatic drive(input int gap_pct, input int reset_at, output bit aborted);
    int idx = 0;
    int budget = 0;
    bit seen_sof = 0;
    bit hold = 0;
    aborted = 0;
    while (idx < items.size()) begin
      @(posedge clock); #1;
      if (reset_at > 0 && got_q.size() >= reset_at) begin
        resetn = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; aborted = 1;
        return;
      end
      if (!hold) begin
        if ($urandom_range(0, 99) < gap_pct) s_tvalid = 1'b0;
        else begin
          s_tvalid = 1'b1; s_tdata = items[idx].data; s_tuser = items[idx].user;
        end
      end
      @(negedge clock); #1;
      hold = s_tvalid && !s_tready;
      if (s_tvalid && s_tready) begin
        if (items[idx].start && !seen_sof) begin
          seen_sof = 1;
          if (fd_q.size() < items[idx].frame) hold_err++;
        end else begin
          idx++;
          seen_sof = 0;
        end
      end
      budget++;
      if (budget > 6000) begin
        checks++; errors++;
        $display("FAIL drive_timeout consumed %0d of %0d items", idx, items.size());
        s_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_fd(input int n);
    int b = 0;
    while (fd_q.size() < n && b < 3000) begin @(negedge clock); b++; end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({m_tvalid, s_tready, m_tdata, m_tuser, m_twin, m_row, m_col, frame_done, err_sync} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%0b r%0b d%0h u%0b w%0b row%0d col%0d fd%0b es%0b want all 0",
               m_tvalid, s_tready, m_tdata, m_tuser, m_twin, m_row, m_col, frame_done, err_sync);
    end
    @(posedge clock); #1; resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL idle_ready got %0b want 1", s_tready); end
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", m_tvalid); end
  endtask

  task automatic test_basic;
    bit ab;
    int nt;
    start_test(0);
    make_frame(0, 0, 0, 1);
    add_frame(0);
    drive(0, 0, ab);
    wait_fd(1);
    checks++;
    if (got_q.size() !== NB) begin errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), NB); end
    nt = 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].twin) nt++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL basic_beat%0d got r%0d c%0d d%0h u%0b w%0b want r%0d c%0d d%0h u%0b w%0b", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, got_q[k].user, got_q[k].twin,
                 exp_q[k].row, exp_q[k].col, exp_q[k].data, exp_q[k].user, exp_q[k].twin);
      end
    end
    checks++;
    if (nt !== NP) begin errors++; $display("FAIL basic_twin_count got %0d want %0d", nt, NP); end
    checks++;
    if (fd_q.size() !== 1) begin errors++; $display("FAIL basic_fd_count got %0d want 1", fd_q.size()); end
    else if (got_q.size() > 0) begin
      checks++;
      if (fd_q[0] !== got_q[got_q.size()-1].cyc + 1) begin
        errors++;
        $display("FAIL basic_fd_timing got cycle %0d want %0d", fd_q[0], got_q[got_q.size()-1].cyc + 1);
      end
    end
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL basic_err_sync got %0d want 0", err_cnt); end
  endtask

  task automatic test_idle_drop;
    bit ab;
    start_test(2);
    make_frame(3, 0, 0, 0);
    add_frame(0);
    drive(30, 0, ab);
    wait_fd(1);
    checks++;
    if (got_q.size() !== NB) begin errors++; $display("FAIL drop_count got %0d want %0d", got_q.size(), NB); end
    else begin
      checks++;
      if (got_q[0].user !== 2'b11 || got_q[0].row !== 8'd0 || got_q[0].col !== 8'd0) begin
        errors++;
        $display("FAIL drop_first got u%0b r%0d c%0d want u11 r0 c0", got_q[0].user, got_q[0].row, got_q[0].col);
      end
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL drop_beat%0d got r%0d c%0d d%0h want r%0d c%0d d%0h", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, exp_q[k].row, exp_q[k].col, exp_q[k].data);
      end
    end
  endtask

  task automatic test_stall;
    bit ab;
    start_test(1);
    make_frame(0, 0, 0, 0);
    add_frame(0);
    drive(0, 0, ab);
    wait_fd(1);
    checks++;
    if (got_q.size() !== NB) begin errors++; $display("FAIL stall_count got %0d want %0d", got_q.size(), NB); end
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_err); end
    checks++;
    if (fd_q.size() !== 1) begin errors++; $display("FAIL stall_fd_count got %0d want 1", fd_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL stall_beat%0d got r%0d c%0d d%0h want r%0d c%0d d%0h", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, exp_q[k].row, exp_q[k].col, exp_q[k].data);
      end
    end
  endtask

  task automatic test_err_sof;
    bit ab;
    start_test(2);
    make_frame(0, 20, 0, 0);
    add_frame(0);
    drive(20, 0, ab);
    wait_fd(1);
    checks++;
    if (err_cnt !== 1) begin errors++; $display("FAIL err_sync_count got %0d want 1", err_cnt); end
    checks++;
    if (got_q.size() !== NB) begin errors++; $display("FAIL err_count got %0d want %0d", got_q.size(), NB); end
    checks++;
    if (fd_q.size() !== 1) begin errors++; $display("FAIL err_fd_count got %0d want 1", fd_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL err_beat%0d got r%0d c%0d d%0h want r%0d c%0d d%0h", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, exp_q[k].row, exp_q[k].col, exp_q[k].data);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ab;
    start_test(0);
    make_frame(0, 0, 0, 0);
    drive(0, 50, ab);
    checks++;
    if (ab !== 1'b1) begin errors++; $display("FAIL rstmid_reached got %0b want 1", ab); end
    @(posedge clock); #1; resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (m_tvalid !== 1'b0 || m_row !== 8'd0 || m_col !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_clear got v%0b r%0d c%0d want v0 r0 c0", m_tvalid, m_row, m_col);
    end
    start_test(0);
    make_frame(0, 0, 0, 0);
    add_frame(0);
    drive(10, 0, ab);
    wait_fd(1);
    checks++;
    if (got_q.size() !== NB) begin errors++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), NB); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL rstmid_beat%0d got r%0d c%0d d%0h want r%0d c%0d d%0h", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, exp_q[k].row, exp_q[k].col, exp_q[k].data);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ab;
    start_test(0);
    make_frame(0, 0, 0, 0);
    make_frame(0, 0, 1, 0);
    add_frame(0);
    add_frame(NP);
    drive(0, 0, ab);
    wait_fd(2);
    checks++;
    if (got_q.size() !== 2 * NB) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 2 * NB); end
    checks++;
    if (fd_q.size() !== 2) begin errors++; $display("FAIL b2b_fd_count got %0d want 2", fd_q.size()); end
    checks++;
    if (hold_err !== 0) begin errors++; $display("FAIL b2b_sof_hold got %0d early SOF takes want 0", hold_err); end
    if (fd_q.size() > 0 && got_q.size() > NB) begin
      checks++;
      if (got_q[NB].cyc <= fd_q[0]) begin
        errors++;
        $display("FAIL b2b_order got frame2 start cycle %0d want after frame_done cycle %0d", got_q[NB].cyc, fd_q[0]);
      end
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].row !== exp_q[k].row || got_q[k].col !== exp_q[k].col ||
          got_q[k].user !== exp_q[k].user || got_q[k].twin !== exp_q[k].twin) begin
        errors++;
        $display("FAIL b2b_beat%0d got r%0d c%0d d%0h want r%0d c%0d d%0h", k,
                 got_q[k].row, got_q[k].col, got_q[k].data, exp_q[k].row, exp_q[k].col, exp_q[k].data);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_idle_drop;
    test_stall;
    test_err_sof;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
